// File: rtl/y86_reg_pkg.sv
// Shared IDs, FSM states and match helper for the Y86-64 register scoreboard.
// Pure types/functions, no timing or flow-control behaviour of its own.
package y86_reg_pkg;

    localparam int NUM_REGS = 15;

    typedef logic [3:0] reg_id_t;

    localparam reg_id_t REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        SB_INIT,
        SB_DONE1,
        SB_RUN
    } sb_state_t;

    // Number of qualified IDs (0..2) that name register r.
    function automatic logic [1:0] hit_count(input reg_id_t r,
                                             input logic    va,
                                             input reg_id_t a,
                                             input logic    vb,
                                             input reg_id_t b);
        hit_count = {1'b0, va && (a == r)} + {1'b0, vb && (b == r)};
    endfunction

endpackage

// File: rtl/reg_pending_counter.sv
// Per-register count of in-flight writes; updates one cycle after inc/dec, room/underflow are combinational.
// Clamps to zero and pulses underflow_o when retires exceed the pending count.
module reg_pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       inc_i,
    input  logic             fire_i,
    input  logic [1:0]       dec_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o,
    output logic             room_o,
    output logic             underflow_o
);
    localparam int SUM_W   = CNT_W + 2;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] up, dn;

    assign up          = SUM_W'(cnt_q) + (fire_i ? SUM_W'(inc_i) : '0);
    assign dn          = SUM_W'(dec_i);
    assign underflow_o = !clear_i && (dn > up);
    // Room is judged on the requested increment, whether or not it fires.
    assign room_o      = (SUM_W'(cnt_q) + SUM_W'(inc_i)) <= SUM_W'(MAX_CNT);
    assign zero_o      = (cnt_q == '0);
    assign cnt_o       = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || underflow_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = CNT_W'(up - dn);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Zero-fills the register file after reset, then gates decode issue on RAW/pending-count hazards.
// issue_ready is combinational from registered counters; retires release a stall the following cycle.
module reg_scoreboard #(
    parameter int NUM_REGS = 15,
    parameter int CNT_W    = 2,
    parameter int DATA_W   = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [3:0]          src_a,
    input  logic [3:0]          src_b,
    input  logic [3:0]          dst_e,
    input  logic [3:0]          dst_m,
    input  logic                retire_e_valid,
    input  logic [3:0]          retire_e_reg,
    input  logic                retire_m_valid,
    input  logic [3:0]          retire_m_reg,
    input  logic                flush,
    output logic                init_we,
    output logic [3:0]          init_reg,
    output logic [DATA_W-1:0]   init_data,
    output logic                init_done,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [31:0]         stall_count,
    output logic                underflow_err
);
    import y86_reg_pkg::*;

    sb_state_t   state_q;
    reg_id_t     idx_q;
    logic        init_we_q;
    reg_id_t     init_reg_q;
    logic        init_done_q;
    logic [31:0] stall_count_q, stall_count_d;
    logic        underflow_q, underflow_d;

    logic [NUM_REGS-1:0] zero, room, uf_pulse, src_hit;
    logic run, cnt_en, clear, fire;

    // Outputs trail state_q by one cycle; init_done_q is the architectural RUN view.
    assign run    = init_done_q;
    assign cnt_en = run && !flush;
    assign clear  = run && flush;
    assign fire   = issue_valid && issue_ready;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam reg_id_t RID = reg_id_t'(r);
        logic [1:0]       inc, dec;
        logic [CNT_W-1:0] cnt;

        assign inc = hit_count(RID, 1'b1, dst_e, 1'b1, dst_m);
        assign dec = cnt_en ? hit_count(RID, retire_e_valid, retire_e_reg,
                                        retire_m_valid, retire_m_reg) : 2'd0;

        reg_pending_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock       (clock),
            .reset       (reset),
            .inc_i       (inc),
            .fire_i      (fire),
            .dec_i       (dec),
            .clear_i     (clear),
            .cnt_o       (cnt),
            .zero_o      (zero[r]),
            .room_o      (room[r]),
            .underflow_o (uf_pulse[r])
        );

        assign src_hit[r] = (cnt != '0) && ((src_a == RID) || (src_b == RID));
    end

    assign issue_ready = run && !flush && !(|src_hit) && (&room);

    assign stall_count_d = (run && issue_valid && !issue_ready && !(&stall_count_q))
                         ? stall_count_q + 32'd1 : stall_count_q;
    assign underflow_d   = underflow_q || (|uf_pulse);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SB_INIT;
            idx_q         <= '0;
            init_we_q     <= 1'b0;
            init_reg_q    <= '0;
            init_done_q   <= 1'b0;
            stall_count_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            case (state_q)
                SB_INIT: begin
                    init_we_q  <= 1'b1;
                    init_reg_q <= idx_q;
                    if (idx_q == reg_id_t'(NUM_REGS - 1)) begin
                        state_q <= SB_DONE1;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                SB_DONE1: begin
                    init_we_q <= 1'b0;
                    state_q   <= SB_RUN;
                end
                SB_RUN: begin
                    init_we_q   <= 1'b0;
                    init_done_q <= 1'b1;
                end
                default: state_q <= SB_INIT;
            endcase
            stall_count_q <= stall_count_d;
            underflow_q   <= underflow_d;
        end
    end

    assign init_we       = init_we_q;
    assign init_reg      = init_reg_q;
    assign init_data     = '0;
    assign init_done     = init_done_q;
    assign busy_mask     = ~zero;
    assign stall_count   = stall_count_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomised + directed bench for reg_scoreboard with a queue-based scoreboard and reference model.
module tb_reg_scoreboard;
    import y86_reg_pkg::*;

    localparam int NR   = 15;
    localparam int MAXC = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [3:0]  src_a = 4'hF, src_b = 4'hF, dst_e = 4'hF, dst_m = 4'hF;
    logic        retire_e_valid = 1'b0, retire_m_valid = 1'b0;
    logic [3:0]  retire_e_reg = 4'hF, retire_m_reg = 4'hF;
    logic        flush = 1'b0;
    logic        issue_ready, init_we, init_done, underflow_err;
    logic [3:0]  init_reg;
    logic [63:0] init_data;
    logic [14:0] busy_mask;
    logic [31:0] stall_count;

    reg_scoreboard dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .src_a(src_a), .src_b(src_b), .dst_e(dst_e), .dst_m(dst_m),
        .retire_e_valid(retire_e_valid), .retire_e_reg(retire_e_reg),
        .retire_m_valid(retire_m_valid), .retire_m_reg(retire_m_reg),
        .flush(flush), .init_we(init_we), .init_reg(init_reg), .init_data(init_data),
        .init_done(init_done), .busy_mask(busy_mask), .stall_count(stall_count),
        .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rdy;
        logic [14:0] busy;
        logic [31:0] stall;
        logic        uf;
        logic        we;
        logic        chk_reg;
        logic [3:0]  ireg;
        logic        done;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: cycles since reset, pending writes per register, stall count, error flag.
    int          cyc_m = 0;
    int          cnt_m[NR];
    logic [31:0] stall_m = '0;
    bit          uf_m = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int inc_of(int r);
        return int'(dst_e == 4'(r)) + int'(dst_m == 4'(r));
    endfunction

    function automatic int dec_of(int r);
        return int'(retire_e_valid && retire_e_reg == 4'(r)) +
               int'(retire_m_valid && retire_m_reg == 4'(r));
    endfunction

    function automatic bit model_ready();
        if (cyc_m < 17 || flush) return 0;
        if (src_a != REG_NONE && cnt_m[src_a] != 0) return 0;
        if (src_b != REG_NONE && cnt_m[src_b] != 0) return 0;
        for (int r = 0; r < NR; r++)
            if (cnt_m[r] + inc_of(r) > MAXC) return 0;
        return 1;
    endfunction

    task automatic model_step();
        bit rdy;
        int n;
        if (reset) begin
            cyc_m   = 0;
            stall_m = '0;
            uf_m    = 0;
            for (int r = 0; r < NR; r++) cnt_m[r] = 0;
        end else begin
            if (cyc_m >= 17) begin
                rdy = model_ready();
                if (issue_valid && !rdy && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
                for (int r = 0; r < NR; r++) begin
                    if (flush) begin
                        cnt_m[r] = 0;
                    end else begin
                        n = cnt_m[r] + ((issue_valid && rdy) ? inc_of(r) : 0) - dec_of(r);
                        if (n < 0) begin
                            n    = 0;
                            uf_m = 1;
                        end
                        cnt_m[r] = n;
                    end
                end
            end
            if (cyc_m < 1000) cyc_m++;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] e, input logic [3:0] m,
                         input logic rev, input logic [3:0] rer,
                         input logic rmv, input logic [3:0] rmr,
                         input logic fl, input logic rst);
        exp_t x;
        @(posedge clock);
        model_step();
        #1;
        issue_valid = v; src_a = a; src_b = b; dst_e = e; dst_m = m;
        retire_e_valid = rev; retire_e_reg = rer;
        retire_m_valid = rmv; retire_m_reg = rmr;
        flush = fl; reset = rst;
        x.rdy   = model_ready();
        for (int r = 0; r < NR; r++) x.busy[r] = (cnt_m[r] != 0);
        x.stall   = stall_m;
        x.uf      = uf_m;
        x.we      = (cyc_m >= 1 && cyc_m <= 15);
        x.chk_reg = (cyc_m <= 15);
        x.ireg    = (cyc_m == 0) ? 4'd0 : 4'(cyc_m - 1);
        x.done    = (cyc_m >= 17);
        expq.push_back(x);
    endtask

    task automatic idle();
        drive(0, REG_NONE, REG_NONE, REG_NONE, REG_NONE, 0, REG_NONE, 0, REG_NONE, 0, 0);
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(3) == 0) ? REG_NONE : 4'($urandom_range(14));
    endfunction

    function automatic logic [3:0] pick_ret();
        int busy[$];
        for (int r = 0; r < NR; r++) if (cnt_m[r] > 0) busy.push_back(r);
        if (busy.size() > 0 && $urandom_range(9) < 8)
            return 4'(busy[$urandom_range(busy.size() - 1)]);
        return rnd_reg();
    endfunction

    task automatic rand_cycle();
        logic v, rev, rmv, fl, rst;
        logic [3:0] a, b, e, m, rer, rmr;
        v   = ($urandom_range(9) < 7);
        a   = rnd_reg(); b = rnd_reg(); e = rnd_reg(); m = rnd_reg();
        rev = ($urandom_range(9) < 3); rer = pick_ret();
        rmv = ($urandom_range(9) < 2); rmr = pick_ret();
        fl  = ($urandom_range(99) < 2);
        rst = ($urandom_range(999) == 0);
        drive(v, a, b, e, m, rev, rer, rmv, rmr, fl, rst);
    endtask

    // Monitor: every cycle the DUT presents outputs, pop and compare.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("issue_ready", 64'(issue_ready), 64'(x.rdy));
                chk("busy_mask", 64'(busy_mask), 64'(x.busy));
                chk("stall_count", 64'(stall_count), 64'(x.stall));
                chk("underflow_err", 64'(underflow_err), 64'(x.uf));
                chk("init_we", 64'(init_we), 64'(x.we));
                chk("init_done", 64'(init_done), 64'(x.done));
                chk("init_data", init_data, 64'd0);
                if (x.chk_reg) chk("init_reg", 64'(init_reg), 64'(x.ireg));
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    localparam logic [3:0] N = 4'hF;

    initial begin
        for (int r = 0; r < NR; r++) cnt_m[r] = 0;
        // Reset and full init sequence, issue_valid held high throughout.
        for (int i = 0; i < 3; i++) drive(0, N, N, N, N, 0, N, 0, N, 0, 1);
        for (int i = 0; i < 18; i++) drive(1, N, N, N, N, 0, N, 0, N, 0, 0);
        @(negedge clock); chk("init_done_after_17", 64'(init_done), 64'd1);

        // RAW on reg 3: four stall cycles, retire releases on the next cycle.
        drive(1, N, N, 4'd3, N, 0, N, 0, N, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 4'd3, N, N, N, 0, N, 0, N, 0, 0);
        drive(1, 4'd3, N, N, N, 1, 4'd3, 0, N, 0, 0);
        drive(1, 4'd3, N, N, N, 0, N, 0, N, 0, 0);
        @(negedge clock);
        chk("stall_after_raw", 64'(stall_count), 64'd4);
        chk("ready_after_retire", 64'(issue_ready), 64'd1);

        // Saturate reg 5 at 3 pending writes.
        drive(1, N, N, 4'd5, 4'd5, 0, N, 0, N, 0, 0);
        drive(1, N, N, 4'd5, N, 0, N, 0, N, 0, 0);
        drive(1, N, N, 4'd5, N, 0, N, 0, N, 0, 0);
        @(negedge clock); chk("ready_saturated", 64'(issue_ready), 64'd0);
        drive(0, N, N, N, N, 1, 4'd5, 1, 4'd5, 0, 0);
        idle();
        @(negedge clock); chk("reg5_one_left", 64'(busy_mask[5]), 64'd1);
        drive(0, N, N, N, N, 1, 4'd5, 0, N, 0, 0);

        // Same-cycle issue and retire on reg 7 nets to no change.
        drive(1, N, N, 4'd7, N, 0, N, 0, N, 0, 0);
        drive(1, N, N, 4'd7, N, 1, 4'd7, 0, N, 0, 0);
        idle();
        @(negedge clock); chk("reg7_net_hold", 64'(busy_mask[7]), 64'd1);

        // Flush clears everything, then a stray retire raises underflow.
        drive(1, N, N, 4'd1, N, 0, N, 0, N, 0, 0);
        drive(1, N, N, 4'd2, N, 0, N, 0, N, 0, 0);
        drive(1, N, N, 4'd4, N, 0, N, 0, N, 0, 0);
        drive(1, N, N, 4'd6, N, 0, N, 0, N, 1, 0);
        idle();
        @(negedge clock); chk("busy_after_flush", 64'(busy_mask), 64'd0);
        drive(0, N, N, N, N, 1, 4'd1, 0, N, 0, 0);
        idle();
        @(negedge clock); chk("underflow_sticky", 64'(underflow_err), 64'd1);

        // Reset while init_reg shows 6.
        drive(0, N, N, N, N, 0, N, 0, N, 0, 1);
        for (int i = 0; i < 7; i++) idle();
        drive(0, N, N, N, N, 0, N, 0, N, 0, 1);
        idle();
        @(negedge clock);
        chk("init_reg_restart", 64'(init_reg), 64'd0);
        chk("stall_cleared", 64'(stall_count), 64'd0);
        chk("busy_cleared", 64'(busy_mask), 64'd0);
        chk("uf_cleared", 64'(underflow_err), 64'd0);

        for (int i = 0; i < 20; i++) idle();
        for (int i = 0; i < 3000; i++) rand_cycle();
        idle();
        idle();

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clock);
        #1;
        if (expq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
